// File: rtl/ex_muldiv_stage_if.sv
// EX/MEM bundle types and the EX-stage handshake interface.
// The package is shared by the stage and anything driving it.
package rv32_pkg;
  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    logic      valid;
    rv32i_word pc;
    logic [4:0] rd;
    rv32i_word rs2;
    rv32i_word alu;
  } stage_regs;
endpackage

interface ex_muldiv_if;
  import rv32_pkg::*;

  stage_regs  regs_in;
  rv32i_word  alu_result;
  rv32i_word  op_a;
  rv32i_word  op_b;
  logic       md_req;
  logic [2:0] md_funct3;
  logic       stall_in;
  stage_regs  regs_out;
  logic       stall_out;
  logic       busy;

  modport master (
    output regs_in, alu_result, op_a, op_b,
    output md_req, md_funct3, stall_in,
    input  regs_out, stall_out, busy
  );

  modport slave (
    input  regs_in, alu_result, op_a, op_b,
    input  md_req, md_funct3, stall_in,
    output regs_out, stall_out, busy
  );
endinterface

// File: rtl/ex_muldiv_stage.sv
// EX output register with an iterative RV32M unit.
// M-ops stall upstream until the result is ready.
module ex_muldiv_stage
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  ex_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  rv32i_word   a_q, a_d;
  rv32i_word   b_q, b_d;
  rv32i_word   res_q, res_d;
  logic        sign_q, sign_d;
  logic [63:0] acc_q, acc_d;
  stage_regs   regs_q, regs_d;

  logic       a_sgnd, b_sgnd;
  logic       a_neg, b_neg;
  logic       special;
  rv32i_word  a_mag, b_mag, spec_res;
  logic [2:0] f3;

  always_comb begin
    f3     = bus.md_funct3;
    a_sgnd = f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
    b_sgnd = f3[2] ? ~f3[0] : ~f3[1];
    a_neg  = a_sgnd & bus.op_a[31];
    b_neg  = b_sgnd & bus.op_b[31];
    a_mag  = a_neg ? -bus.op_a : bus.op_a;
    b_mag  = b_neg ? -bus.op_b : bus.op_b;
    special = f3[2] & ((bus.op_b == '0) |
              (~f3[0] & (bus.op_a == 32'h8000_0000) &
               (bus.op_b == 32'hFFFF_FFFF)));
    if (bus.op_b == '0)
      spec_res = f3[1] ? bus.op_a : 32'hFFFF_FFFF;
    else
      spec_res = f3[1] ? 32'h0 : 32'h8000_0000;
  end

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic        ge;
  rv32i_word   diff, dres, dres_s, fin;
  logic [63:0] step, prod;

  // acc holds {remainder, quotient} for divide, {hi, lo} for multiply
  always_comb begin
    sum    = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? a_q : 32'h0};
    rem_sh = acc_q[63:31];
    ge     = rem_sh >= {1'b0, b_q};
    diff   = rem_sh[31:0] - b_q;
    if (f3_q[2])
      step = ge ? {diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    else
      step = {sum, acc_q[31:1]};
    prod   = sign_q ? -step : step;
    dres   = f3_q[1] ? step[63:32] : step[31:0];
    dres_s = sign_q ? -dres : dres;
    if (f3_q[2])
      fin = dres_s;
    else if (f3_q[1:0] == 2'b00)
      fin = prod[31:0];
    else
      fin = prod[63:32];
  end

  logic stall, load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    res_d   = res_q;
    regs_d  = regs_q;
    stall   = bus.md_req && (state_q != DONE);
    load    = ~stall & ~bus.stall_in;
    unique case (state_q)
      IDLE: begin
        if (bus.md_req) begin
          f3_d   = f3;
          a_d    = a_mag;
          b_d    = b_mag;
          sign_d = f3[2] & f3[1] ? a_neg : a_neg ^ b_neg;
          cnt_d  = '0;
          if (special) begin
            res_d   = spec_res;
            state_d = DONE;
          end else begin
            acc_d   = {32'h0, f3[2] ? a_mag : b_mag};
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          res_d   = fin;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      regs_d     = bus.regs_in;
      regs_d.alu = (state_q == DONE) ? res_q : bus.alu_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      regs_q  <= regs_d;
    end
  end

  assign bus.regs_out  = regs_q;
  assign bus.stall_out = stall;
  assign bus.busy      = (state_q == BUSY);

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage: vector table, corner sequences
// and randomized ops against an arithmetic reference model.
module tb_ex_muldiv_stage;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_if bus();

  ex_muldiv_stage dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    int sa, sb;
    longint la, lb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    ua = {32'h0, a};
    ub = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = la * lb; return p[31:0]; end
      3'd1: begin p = la * lb; return p[63:32]; end
      3'd2: begin p = la * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  task automatic set_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] tag);
    bus.md_req        = 1'b1;
    bus.md_funct3     = f3;
    bus.op_a          = a;
    bus.op_b          = b;
    bus.alu_result    = 32'hDEAD_BEEF;
    bus.regs_in.valid = 1'b1;
    bus.regs_in.pc    = tag;
    bus.regs_in.rd    = 5'd3;
    bus.regs_in.rs2   = b;
    bus.regs_in.alu   = 32'h0;
  endtask

  // Issues one M-op; counts cycles with stall_out/busy high.
  task automatic do_md(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] tag,
                       output int nstall, output int nbusy,
                       output logic [31:0] res, output logic [31:0] pc);
    set_op(f3, a, b, tag);
    nstall = 0;
    nbusy  = 0;
    #1;
    while (bus.stall_out && nstall < 100) begin
      nstall++;
      if (bus.busy) nbusy++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    res        = bus.regs_out.alu;
    pc         = bus.regs_out.pc;
    bus.md_req = 1'b0;
  endtask

  task automatic run_chk(input string nm, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat,
                         input logic [31:0] tag);
    int ns, nb;
    logic [31:0] r, pc;
    do_md(f3, a, b, tag, ns, nb, r, pc);
    chk({nm, "_stall"}, 64'(ns), 64'(lat));
    chk({nm, "_busy"}, 64'(nb), 64'(lat == 33 ? 32 : 0));
    chk({nm, "_res"}, {32'h0, r}, {32'h0, exp});
    chk({nm, "_pc"}, {32'h0, pc}, {32'h0, tag});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c[6];
    c[0] = 32'h0;
    c[1] = 32'hFFFF_FFFF;
    c[2] = 32'h8000_0000;
    c[3] = 32'h7FFF_FFFF;
    c[4] = 32'h1;
    c[5] = 32'h2;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  int n;
  logic [31:0] prev, ra, rb, rexp;
  logic [2:0]  rf3;

  initial begin
    vt[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33};
    vt[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vt[2]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vt[3]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vt[4]  = '{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1};
    vt[5]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[6]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
    vt[7]  = '{3'd7, 32'd13,        32'd0,         32'd13,        1};
    vt[8]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vt[9]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vt[10] = '{3'd4, 32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFE, 33};
    vt[11] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33};

    reset          = 1'b1;
    bus.md_req     = 1'b0;
    bus.md_funct3  = 3'd0;
    bus.op_a       = 32'h0;
    bus.op_b       = 32'h0;
    bus.alu_result = 32'h0;
    bus.stall_in   = 1'b0;
    bus.regs_in    = '0;
    #1;
    chk("rst_regs_zero", 64'(bus.regs_out == '0), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_stall", 64'(bus.stall_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // plain ALU passthrough, then held by downstream stall
    @(negedge clk);
    bus.alu_result    = 32'h7;
    bus.regs_in.valid = 1'b1;
    bus.regs_in.pc    = 32'h100;
    #1;
    chk("add_stall_out", 64'(bus.stall_out), 64'd0);
    @(posedge clk);
    #1;
    chk("add_alu", {32'h0, bus.regs_out.alu}, 64'h7);
    chk("add_valid", 64'(bus.regs_out.valid), 64'd1);
    bus.alu_result = 32'h9;
    bus.stall_in   = 1'b1;
    @(posedge clk);
    #1;
    chk("add_hold", {32'h0, bus.regs_out.alu}, 64'h7);
    bus.stall_in = 1'b0;

    @(negedge clk);
    foreach (vt[i])
      run_chk($sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b,
              vt[i].exp, vt[i].lat, 32'h200 + 32'(i));

    // async reset in the middle of an iterative op
    @(negedge clk);
    set_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'h300);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_busy_before", 64'(bus.busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_regs_zero", 64'(bus.regs_out == '0), 64'd1);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_stall", 64'(bus.stall_out), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    run_chk("midrst_redo", 3'd0, 32'hFFFF_FFFD, 32'd5,
            32'hFFFF_FFF1, 33, 32'h300);

    // result held in DONE while mem stalls
    @(negedge clk);
    bus.stall_in = 1'b1;
    set_op(3'd5, 32'd1000, 32'd7, 32'h400);
    n = 0;
    #1;
    while (bus.stall_out && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("dstall_stall", 64'(n), 64'd33);
    prev = bus.regs_out.alu;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("dstall_busy", 64'(bus.busy), 64'd0);
      chk("dstall_in_done", 64'(bus.stall_out), 64'd0);
      chk("dstall_hold", {32'h0, bus.regs_out.alu}, {32'h0, prev});
    end
    bus.stall_in = 1'b0;
    @(posedge clk);
    #1;
    chk("dstall_res", {32'h0, bus.regs_out.alu}, 64'd142);
    bus.md_req = 1'b0;
    @(posedge clk);
    #1;
    chk("dstall_no_restart", 64'(bus.busy), 64'd0);

    // back-to-back divides, no dead cycle between them
    @(negedge clk);
    run_chk("b2b_a", 3'd5, 32'd20, 32'd3, 32'd6, 33, 32'h500);
    run_chk("b2b_b", 3'd5, 32'd9, 32'd4, 32'd2, 33, 32'h504);

    for (int i = 0; i < 40; i++) begin
      rf3  = 3'($urandom_range(0, 7));
      ra   = pick();
      rb   = pick();
      rexp = ref_md(rf3, ra, rb);
      run_chk($sformatf("rnd%0d_f%0d", i, rf3), rf3, ra, rb, rexp,
              ref_lat(rf3, ra, rb), 32'h1000 + 32'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
